alu_wb_stage: RTL

//  Downstream stage of the ALU. Captures each ALU result and its NZCV flags,

---
 rtl/alu_wb_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// ---------------------------------------------------------------------------
// alu_wb_stage
//
// Downstream stage of the ALU. Each accepted ALU op has its condition code
// evaluated against the architectural NZCV status register. The status
// register is updated only when the condition passes. Every op, pass or
// fail, is then queued in order in a DEPTH-entry FIFO on its way to
// register-file write-back.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds valid and its payload
// stable until that edge. in_ready comes only from registered state, so it
// never depends combinationally on in_valid or out_ready.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       upstream op valid
//   in_ready       stage can accept an op this cycle
//   in_result      ALU result
//   in_flags       ALU flags {N,Z,C,V}
//   in_cond        condition code (EQ..AL, 4'hF behaves as AL)
//   in_flag_wr     [1] update N,Z  [0] update C,V (only when condition passes)
//   in_reg_wr      op writes a register
//   in_rd          destination register index
//   out_valid      head entry valid
//   out_ready      downstream accepts head entry
//   out_result     head result
//   out_rd         head destination index
//   out_exec       head condition passed
//   out_we         out_valid & out_exec & stored reg_wr
//   status_flags   architectural {N,Z,C,V}
//   dbg_count      FIFO occupancy, exposed so checkers can bind to it
// ---------------------------------------------------------------------------
module alu_wb_stage #(
    parameter int WIDTH = 5,
    parameter int RD_W  = 3,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_result,
    input  logic [3:0]                   in_flags,
    input  logic [3:0]                   in_cond,
    input  logic [1:0]                   in_flag_wr,
    input  logic                         in_reg_wr,
    input  logic [RD_W-1:0]              in_rd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic [RD_W-1:0]              out_rd,
    output logic                         out_exec,
    output logic                         out_we,
    output logic [3:0]                   status_flags,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             exec;
        logic             reg_wr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] remain;
    logic             ready_en;
    logic             out_reg_wr;
    logic             push;
    logic             pop;
    logic             cond_pass;
    entry_t           in_entry;
    entry_t           head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ready_en is low throughout reset and rises on the first edge after
    // release, so ops offered during or around reset are never taken.
    assign in_ready  = ready_en & (count < CNT_W'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_we    = out_valid & out_exec & out_reg_wr;
    assign dbg_count = count;

    // Condition check against the status as it stands this cycle, which
    // already includes every earlier accepted op.
    always_comb begin
        logic n, z, c, v;
        n = status_flags[3];
        z = status_flags[2];
        c = status_flags[1];
        v = status_flags[0];
        cond_pass = 1'b1;
        case (in_cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c & !z;
            4'h9:    cond_pass = !c | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    always_comb begin
        in_entry.result = in_result;
        in_entry.rd     = in_rd;
        in_entry.exec   = cond_pass;
        in_entry.reg_wr = in_reg_wr;
    end

    // Next head: when nothing remains in storage after a pop, the only
    // possible head is the op being pushed this cycle; otherwise it is the
    // entry at the (possibly advanced) read pointer.
    always_comb begin
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        remain     = count - CNT_W'(pop);
        rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
        head_nxt   = (remain == '0) ? in_entry : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            count    <= count_nxt;
            rd_ptr   <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    // Head register: reloaded whenever the FIFO will be non-empty, and left
    // alone when it drains so out_* keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_exec   <= 1'b0;
            out_reg_wr <= 1'b0;
        end else begin
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                out_result <= head_nxt.result;
                out_rd     <= head_nxt.rd;
                out_exec   <= head_nxt.exec;
                out_reg_wr <= head_nxt.reg_wr;
            end
        end
    end

    // A failed op leaves the flags untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_flags <= 4'b0000;
        end else if (push && cond_pass) begin
            if (in_flag_wr[1]) begin
                status_flags[3:2] <= in_flags[3:2];
            end
            if (in_flag_wr[0]) begin
                status_flags[1:0] <= in_flags[1:0];
            end
        end
    end

endmodule
